// File: rtl/connect4_pkg.sv
// connect4_pkg: board geometry, sequencer state encoding and cell indexing.
package connect4_pkg;
  localparam int NCOLS = 7;
  localparam int NROWS = 6;
  localparam int CELL  = 16;
  typedef enum logic [2:0] {IDLE, CHECK, DRAW, FLUSH, DONE} state_t;
  function automatic logic [5:0] idx(input logic [2:0] row, input logic [2:0] col);
    return 6'(32'(row) * NCOLS + 32'(col));
  endfunction
endpackage

// File: rtl/column_lowest_free.sv
// column_lowest_free: lowest empty row of one column (bit 0 = bottom) and full flag.
module column_lowest_free
  import connect4_pkg::*;
(
  input  logic [NROWS-1:0] i_col_occ,
  output logic [2:0]       o_row,
  output logic             o_full
);
  always_comb begin
    o_row = '0;
    for (int i = NROWS - 1; i >= 0; i--)
      o_row = i_col_occ[i] ? o_row : 3'(i);
  end
  assign o_full = &i_col_occ;
endmodule

// File: rtl/chip_drop_ctrl.sv
// chip_drop_ctrl: sequences a column drop through landing-row search, one sprite
// draw pass and the board commit, keeping occupancy, colours and turn.
module chip_drop_ctrl
  import connect4_pkg::*;
#(
  parameter int X0          = 24,
  parameter int Y0          = 16,
  parameter int PITCH       = CELL,
  parameter int DRAW_CYCLES = 256,
  parameter int PLOT_LAT    = 2
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   drop_req,
  input  logic [2:0]             col,
  input  logic                   clear_board,
  output logic [7:0]             xout,
  output logic [6:0]             yout,
  output logic                   drawr,
  output logic                   drawb,
  output logic                   plot,
  output logic                   busy,
  output logic                   done,
  output logic                   illegal,
  output logic                   turn,
  output logic [NROWS*NCOLS-1:0] occ,
  output logic [NROWS*NCOLS-1:0] chip_col,
  output logic                   board_full
);
  state_t                 r_state;
  logic [2:0]             r_col, r_row;
  logic [7:0]             r_cnt, r_xout;
  logic [6:0]             r_yout;
  logic [PLOT_LAT-1:0]    r_pipe;
  logic                   r_drawr, r_drawb, r_done, r_illegal, r_turn;
  logic [NROWS*NCOLS-1:0] r_occ, r_chip;
  logic [2:0]             w_sel, w_row;
  logic [NROWS-1:0]       w_col_occ;
  logic                   w_col_full, w_board_full;
  // In IDLE the requested column is probed (clamped so col=7 stays in range);
  // afterwards the latched column drives the search.
  assign w_sel = (r_state == IDLE) ? ((col > 3'd6) ? 3'd6 : col) : r_col;
  always_comb begin
    w_col_occ = '0;
    for (int i = 0; i < NROWS; i++)
      w_col_occ[i] = r_occ[idx(3'(i), w_sel)];
  end
  column_lowest_free u_clf (
    .i_col_occ (w_col_occ),
    .o_row     (w_row),
    .o_full    (w_col_full)
  );
  assign w_board_full = &r_occ;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_cnt     <= '0;
      r_xout    <= '0;
      r_yout    <= '0;
      r_pipe    <= '0;
      r_drawr   <= 1'b0;
      r_drawb   <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_turn    <= 1'b0;
      r_occ     <= '0;
      r_chip    <= '0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      r_pipe    <= {r_pipe[PLOT_LAT-2:0], r_drawr | r_drawb};
      case (r_state)
        IDLE: begin
          if (clear_board) begin
            r_occ  <= '0;
            r_chip <= '0;
            r_turn <= 1'b0;
          end else if (drop_req) begin
            if (col > 3'd6 || w_col_full || w_board_full) r_illegal <= 1'b1;
            else begin
              r_col   <= col;
              r_state <= CHECK;
            end
          end
        end
        CHECK: begin
          r_row   <= w_row;
          r_xout  <= 8'(9'(X0 + 32'(r_col) * PITCH));
          r_yout  <= 7'(9'(Y0 + (NROWS - 1 - 32'(w_row)) * PITCH));
          r_cnt   <= '0;
          r_drawr <= ~r_turn;
          r_drawb <= r_turn;
          r_state <= DRAW;
        end
        DRAW: begin
          if (r_cnt == 8'(DRAW_CYCLES - 1)) begin
            r_drawr <= 1'b0;
            r_drawb <= 1'b0;
            r_cnt   <= '0;
            r_state <= FLUSH;
          end else r_cnt <= r_cnt + 8'd1;
        end
        FLUSH: begin
          if (r_cnt == 8'(PLOT_LAT - 1)) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else r_cnt <= r_cnt + 8'd1;
        end
        DONE: begin
          r_occ[idx(r_row, r_col)]  <= 1'b1;
          r_chip[idx(r_row, r_col)] <= r_turn;
          r_turn                    <= ~r_turn;
          r_state                   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign xout       = r_xout;
  assign yout       = r_yout;
  assign drawr      = r_drawr;
  assign drawb      = r_drawb;
  assign plot       = r_pipe[PLOT_LAT-1];
  assign busy       = r_state != IDLE;
  assign done       = r_done;
  assign illegal    = r_illegal;
  assign turn       = r_turn;
  assign occ        = r_occ;
  assign chip_col   = r_chip;
  assign board_full = w_board_full;
endmodule

// File: tb/tb_chip_drop_ctrl.sv
// tb_chip_drop_ctrl: random column drops against a column-height board model,
// with a queue-based scoreboard checking each draw pass, done and illegal pulse.
module tb_chip_drop_ctrl;
  logic clk = 1'b0, resetn = 1'b0, drop_req = 1'b0, clear_board = 1'b0;
  logic [2:0] col = '0;
  logic [7:0] xout;
  logic [6:0] yout;
  logic drawr, drawb, plot, busy, done, illegal, turn, board_full;
  logic [41:0] occ, chip_col;

  chip_drop_ctrl dut (
    .clk(clk), .resetn(resetn), .drop_req(drop_req), .col(col), .clear_board(clear_board),
    .xout(xout), .yout(yout), .drawr(drawr), .drawb(drawb), .plot(plot), .busy(busy),
    .done(done), .illegal(illegal), .turn(turn), .occ(occ), .chip_col(chip_col),
    .board_full(board_full)
  );

  always #5 clk = ~clk;

  typedef struct {bit ill; int x; int y; bit blue; int issue;} exp_t;
  exp_t q[$];
  int cyc = 0, n_pass = 0, n_total = 0, n_done = 0, n_ill = 0;
  int h[7];
  bit colr[7][6];
  bit turn_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    else n_pass++;
  endtask

  // Monitor: accumulates one draw pass, then retires it against the queue on done.
  int sc = 0, pc = 0, ss, ps, pl, sx, sy;
  bit sb, unstable = 0, ok;
  exp_t e;
  always @(negedge clk) begin
    if (!resetn) begin
      sc = 0; pc = 0; unstable = 0;
    end else begin
      if (drawr | drawb) begin
        if (sc == 0) begin ss = cyc; sx = xout; sy = yout; sb = drawb; end
        else if (xout != 8'(sx) || yout != 7'(sy) || drawb != sb) unstable = 1;
        if (drawr === drawb) unstable = 1;
        sc++;
      end
      if (plot) begin
        if (pc == 0) ps = cyc;
        pl = cyc; pc++;
      end
      if (done) begin
        ok = q.size() != 0 && !q[0].ill;
        chk("done_expected", ok, 1);
        if (ok) begin
          e = q.pop_front();
          chk("xout", sx, e.x);
          chk("yout", sy, e.y);
          chk("strobe_colour_blue", sb, e.blue);
          chk("strobe_stable", unstable, 0);
          chk("strobe_len", sc, 256);
          chk("plot_len", pc, 256);
          chk("strobe_start", ss - e.issue, 2);
          chk("plot_start", ps - e.issue, 4);
          chk("plot_end", pl - e.issue, 259);
          chk("done_cycle", cyc - e.issue, 260);
        end
        sc = 0; pc = 0; unstable = 0; n_done++;
      end
      if (illegal) begin
        ok = q.size() != 0 && q[0].ill;
        chk("illegal_expected", ok, 1);
        if (ok) begin
          e = q.pop_front();
          chk("illegal_latency", cyc - e.issue, 1);
          chk("illegal_no_strobe", sc, 0);
        end
        n_ill++;
      end
    end
  end

  function automatic int filled();
    int s = 0;
    for (int c = 0; c < 7; c++) s += h[c];
    return s;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 7; c++) begin
      h[c] = 0;
      for (int r = 0; r < 6; r++) colr[c][r] = 0;
    end
    turn_m = 0;
  endtask

  task automatic chk_state();
    logic [41:0] eo = '0, ec = '0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < h[c]; r++) begin
        eo[r*7+c] = 1'b1;
        ec[r*7+c] = colr[c][r];
      end
    chk("occ", occ, eo);
    chk("chip_col", chip_col, ec);
    chk("turn", turn, turn_m);
    chk("board_full", board_full, filled() == 42);
    chk("busy_idle", busy, 0);
  endtask

  task automatic do_drop(input int c, input bit poke);
    bit legal = c < 7 && h[c] < 6;
    int nd, ni;
    exp_t x;
    @(posedge clk); #1;
    nd = n_done; ni = n_ill;
    x.ill = !legal; x.x = 24 + c * 16; x.y = legal ? 16 + (5 - h[c]) * 16 : 0;
    x.blue = turn_m; x.issue = cyc;
    q.push_back(x);
    drop_req = 1; col = 3'(c);
    @(posedge clk); #1;
    drop_req = 0;
    if (legal) begin
      for (int i = 0; i < 400 && !done; i++) begin
        @(negedge clk);
        if (poke && i == 50) begin
          drop_req = 1; col = 3'($urandom_range(0, 7)); clear_board = 1;
        end else begin
          drop_req = 0; clear_board = 0;
        end
      end
      chk("done_seen", done, 1);
      drop_req = 0; clear_board = 0;
      @(posedge clk); #1;
      chk("done_count", n_done - nd, 1);
      colr[c][h[c]] = turn_m;
      h[c]++;
      turn_m = ~turn_m;
    end else begin
      @(posedge clk); #1;
      chk("illegal_count", n_ill - ni, 1);
    end
    chk_state();
  endtask

  task automatic do_clear(input bit with_drop);
    @(posedge clk); #1;
    clear_board = 1; drop_req = with_drop; col = 3'($urandom_range(0, 6));
    @(posedge clk); #1;
    clear_board = 0; drop_req = 0;
    model_clear();
    @(posedge clk); #1;
    chk_state();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_xout", xout, 0);
    chk("rst_yout", yout, 0);
    chk("rst_drawr", drawr, 0);
    chk("rst_drawb", drawb, 0);
    chk("rst_plot", plot, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_turn", turn, 0);
    chk("rst_occ", occ, 0);
    chk("rst_chip_col", chip_col, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int nd, c, guard;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    resetn = 1;
    // Two chips stacked in column 3: red at the bottom, blue above.
    do_drop(3, 0);
    do_drop(3, 0);
    // Fill column 0, then overfill it.
    for (int i = 0; i < 6; i++) do_drop(0, 0);
    do_drop(0, 0);
    do_drop(7, 0);
    // Requests and clears while busy must be ignored.
    do_drop(5, 1);
    // Clear and drop together: clear wins.
    do_clear(1);
    // Reset at draw cycle 100 aborts the move.
    @(posedge clk); #1;
    nd = n_done;
    drop_req = 1; col = 3'($urandom_range(0, 6));
    @(posedge clk); #1;
    drop_req = 0;
    repeat (101) @(posedge clk);
    #1;
    resetn = 0;
    @(posedge clk); #1;
    chk_reset_outputs();
    resetn = 1;
    q.delete();
    model_clear();
    repeat (300) @(posedge clk);
    #1;
    chk("no_done_after_reset", n_done - nd, 0);
    chk_state();
    // Random fill until the board is full, with illegal choices mixed in.
    guard = 0;
    while (filled() < 42 && guard < 2000) begin
      c = $urandom_range(0, 7);
      do_drop(c, $urandom_range(0, 7) == 0);
      guard++;
    end
    chk("board_filled", filled(), 42);
    do_drop($urandom_range(0, 6), 0);
    do_clear(0);
    do_drop($urandom_range(0, 6), 0);
    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
